// File: rtl/seq_detector_param.sv
// seq_detector_param: generic serial bit-pattern detector with a saturating
// match counter. It tracks P, the length of the longest pattern prefix that is
// also a suffix of the accepted bits. Both the transition table and the match
// condition are derived from PATTERN at elaboration time.
module seq_detector_param #(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] PATTERN = 3'b010,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xin,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int PW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef logic [PW-1:0] progress_t;

  localparam progress_t LAST_PROGRESS = progress_t'(SEQ_LEN - 1);

  // Pattern lengths outside 2..16 cannot be built; stop at elaboration.
  if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
    $error("seq_detector_param: SEQ_LEN must lie in 2..16");
  end

  // Progress after appending bit b to prefix(p). The candidate is prefix(p)
  // followed by b. The result is the longest prefix of PATTERN, shorter than
  // SEQ_LEN, that ends the candidate. When the candidate is a full hit and
  // overlap is disabled, matching starts again from nothing.
  function automatic int nextProgress(input int p, input int b);
    int pat;
    int cand;
    int limit;
    int best;
    int pre;
    int suf;
    pat  = int'(PATTERN);
    cand = ((pat >> (SEQ_LEN - p)) << 1) | b;
    if ((p == SEQ_LEN - 1) && (cand == pat) && !OVERLAP) begin
      return 0;
    end
    limit = (p + 1 < SEQ_LEN) ? p + 1 : SEQ_LEN - 1;
    best  = 0;
    for (int k = 1; k <= limit; k++) begin
      pre = pat >> (SEQ_LEN - k);
      suf = cand & ((1 << k) - 1);
      if (pre == suf) begin
        best = k;
      end
    end
    return best;
  endfunction

  progress_t stepTbl0 [SEQ_LEN];
  progress_t stepTbl1 [SEQ_LEN];

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_tbl
    localparam progress_t NEXT_ON_0 = progress_t'(nextProgress(g, 0));
    localparam progress_t NEXT_ON_1 = progress_t'(nextProgress(g, 1));
    assign stepTbl0[g] = NEXT_ON_0;
    assign stepTbl1[g] = NEXT_ON_1;
  end

  progress_t        progress_q, progress_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             hit;

  // Register the progress state and all outputs. Reset drops any partial match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      progress_q <= '0;
      y_q        <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      progress_q <= progress_d;
      y_q        <= y_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
    end
  end

  // Advance the progress on enabled samples. A hit is the final pattern bit
  // arriving while all earlier pattern bits are already matched.
  always_comb begin
    progress_d = progress_q;
    hit        = 1'b0;
    if (en) begin
      progress_d = xin ? stepTbl1[progress_q] : stepTbl0[progress_q];
      hit        = (progress_q == LAST_PROGRESS) && (xin == PATTERN[0]);
    end
  end

  // Pulse y for every hit. The counter saturates instead of wrapping, and a
  // lost increment sets the sticky sat flag. clr_cnt wins over a hit.
  always_comb begin
    y_d     = hit;
    count_d = count_q;
    sat_d   = sat_q;
    if (clr_cnt) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (hit) begin
      if (&count_q) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  assign y     = y_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Three instances share one input stream:
// the default 010 detector with overlap, a non-overlapping 010 detector with
// a 4-bit counter, and an overlapping 11011 detector with a 4-bit counter.
// A history-based reference model predicts every output on every cycle.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       xin = 1'b0;
  logic       en = 1'b0;
  logic       clrCnt = 1'b0;

  logic       yDef;
  logic [9:0] countDef;
  logic       satDef;
  logic       yNo;
  logic [3:0] countNo;
  logic       satNo;
  logic       yLong;
  logic [3:0] countLong;
  logic       satLong;

  int nCompared = 0;
  int nMismatched = 0;

  // Model configuration, indexed 0=default, 1=non-overlap, 2=long pattern
  int mLen [3] = '{3, 3, 5};
  int mPat [3] = '{2, 2, 27};
  bit mOvl [3] = '{1'b1, 1'b0, 1'b1};
  int mCw  [3] = '{10, 4, 4};

  bit histQ [3][$];
  int expY [3];
  int expCnt [3];
  int expSat [3];
  int pulses [3];

  seq_detector_param dutDef (
    .clk(clk), .rst(rst), .xin(xin), .en(en), .clr_cnt(clrCnt),
    .y(yDef), .count(countDef), .sat(satDef)
  );

  seq_detector_param #(
    .SEQ_LEN(3), .PATTERN(3'b010), .OVERLAP(1'b0), .CNT_W(4)
  ) dutNo (
    .clk(clk), .rst(rst), .xin(xin), .en(en), .clr_cnt(clrCnt),
    .y(yNo), .count(countNo), .sat(satNo)
  );

  seq_detector_param #(
    .SEQ_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(4)
  ) dutLong (
    .clk(clk), .rst(rst), .xin(xin), .en(en), .clr_cnt(clrCnt),
    .y(yLong), .count(countLong), .sat(satLong)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // One comparison: bump the counters and report any mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // True when the last accepted bits of instance i spell out its pattern
  function automatic bit endsWithPattern(input int i);
    int sz;
    sz = histQ[i].size();
    if (sz < mLen[i]) return 1'b0;
    for (int j = 0; j < mLen[i]; j++) begin
      if (int'(histQ[i][sz - mLen[i] + j]) != ((mPat[i] >> (mLen[i] - 1 - j)) & 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: keep the accepted bit history per instance. A hit occurs
  // when the history ends in the pattern. Non-overlap mode forgets the history
  // after a hit. The counter saturates at its maximum value.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        histQ[i].delete();
        expY[i] = 0;
        expCnt[i] = 0;
        expSat[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit hitNow;
        hitNow = 1'b0;
        if (en) begin
          histQ[i].push_back(xin);
          if (histQ[i].size() > 16) void'(histQ[i].pop_front());
          hitNow = endsWithPattern(i);
          if (hitNow && !mOvl[i]) histQ[i].delete();
        end
        expY[i] = hitNow ? 1 : 0;
        if (clrCnt) begin
          expCnt[i] = 0;
          expSat[i] = 0;
        end else if (hitNow) begin
          if (expCnt[i] == (1 << mCw[i]) - 1) expSat[i] = 1;
          else expCnt[i] = expCnt[i] + 1;
        end
      end
    end
  end

  // Compare every DUT output with the model shortly after each rising edge,
  // and count the y pulses seen on each instance
  always @(posedge clk) begin
    #2;
    checkOutput("def.y", int'(yDef), expY[0]);
    checkOutput("def.count", int'(countDef), expCnt[0]);
    checkOutput("def.sat", int'(satDef), expSat[0]);
    checkOutput("noovl.y", int'(yNo), expY[1]);
    checkOutput("noovl.count", int'(countNo), expCnt[1]);
    checkOutput("noovl.sat", int'(satNo), expSat[1]);
    checkOutput("long.y", int'(yLong), expY[2]);
    checkOutput("long.count", int'(countLong), expCnt[2]);
    checkOutput("long.sat", int'(satLong), expSat[2]);
    if (yDef) pulses[0]++;
    if (yNo) pulses[1]++;
    if (yLong) pulses[2]++;
  end

  // Drive one sample on the falling edge, then wait until just after the
  // rising edge that consumes it
  task automatic applyStimulus(input bit x, input bit e, input bit c);
    @(negedge clk);
    xin = x;
    en = e;
    clrCnt = c;
    @(posedge clk);
    #3;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    clrCnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send010(input int reps);
    for (int r = 0; r < reps; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  // Guard against a hung run
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with hand-computed checkpoints, then random traffic
  initial begin
    int base0;
    int base1;
    int base2;
    bit s1;
    bit s2;
    bit s3;

    #2;
    checkOutput("reset.y", int'(yDef), 0);
    checkOutput("reset.count", int'(countDef), 0);
    checkOutput("reset.sat", int'(satDef), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] 010 stream repeated 1000 times");
    base0 = pulses[0];
    send010(1000);
    checkOutput("t1.def.count", int'(countDef), 1000);
    checkOutput("t1.def.sat", int'(satDef), 0);
    checkOutput("t1.def.pulses", pulses[0] - base0, 1000);
    checkOutput("t1.noovl.count", int'(countNo), 15);
    checkOutput("t1.noovl.sat", int'(satNo), 1);
    checkOutput("t1.long.count", int'(countLong), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1.clr.def.count", int'(countDef), 0);
    checkOutput("t1.clr.noovl.sat", int'(satNo), 0);

    $display("[TB] overlap versus non-overlap");
    pulseReset();
    base0 = pulses[0];
    base1 = pulses[1];
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2.def.count", int'(countDef), 2);
    checkOutput("t2.noovl.count", int'(countNo), 1);
    checkOutput("t2.def.pulses", pulses[0] - base0, 2);
    checkOutput("t2.noovl.pulses", pulses[1] - base1, 1);

    $display("[TB] saturation of the 4-bit counter");
    pulseReset();
    base1 = pulses[1];
    send010(15);
    checkOutput("t3.count15", int'(countNo), 15);
    checkOutput("t3.sat15", int'(satNo), 0);
    send010(1);
    checkOutput("t3.count16", int'(countNo), 15);
    checkOutput("t3.sat16", int'(satNo), 1);
    send010(4);
    checkOutput("t3.pulses", pulses[1] - base1, 20);
    checkOutput("t3.count20", int'(countNo), 15);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3.clr.count", int'(countNo), 0);
    checkOutput("t3.clr.sat", int'(satNo), 0);

    $display("[TB] clear on the matching edge");
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4.y", int'(yDef), 1);
    checkOutput("t4.count", int'(countDef), 0);
    send010(1);
    checkOutput("t4.next.count", int'(countDef), 1);

    $display("[TB] enable gating");
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    base0 = pulses[0];
    for (int k = 0; k < 5; k++) applyStimulus(k[0], 1'b0, 1'b0);
    checkOutput("t5.gap.pulses", pulses[0] - base0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5.y", int'(yDef), 1);
    checkOutput("t5.count", int'(countDef), 1);

    $display("[TB] reset in the middle of a pattern");
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t6.y", int'(yDef), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t6.count", int'(countDef), 1);

    $display("[TB] 11011 on 1,1,0,1,1,0,1,1");
    pulseReset();
    base2 = pulses[2];
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t6.long.count", int'(countLong), 2);
    checkOutput("t6.long.pulses", pulses[2] - base2, 2);

    $display("[TB] random traffic");
    pulseReset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulseReset();
      end else begin
        s1 = 1'($urandom_range(0, 1));
        s2 = ($urandom_range(0, 9) < 8);
        s3 = ($urandom_range(0, 31) == 0);
        applyStimulus(s1, s2, s3);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
